// File: rtl/dds_pkg.sv
// dds_pkg: shared widths, one-hot waveform codes, midscale and selection-validity helper for the DDS core
package dds_pkg;
  localparam int ACC_W = 32;
  localparam int ADDR_W = 12;
  localparam int DATA_W = 8;
  localparam logic [DATA_W-1:0] MIDSCALE = 8'd128;
  localparam logic [3:0] WAVE_MUTE = 4'b0000;
  localparam logic [3:0] WAVE_SINE = 4'b0001;
  localparam logic [3:0] WAVE_SQUARE = 4'b0010;
  localparam logic [3:0] WAVE_TRI = 4'b0100;
  localparam logic [3:0] WAVE_SAW = 4'b1000;
  function automatic logic sel_ok(input logic [3:0] s);
    return (s & (s - 4'd1)) == 4'd0;
  endfunction
endpackage

// File: rtl/dds_wave_gen_if.sv
// dds_wave_gen_if: DDS bus; master drives dds_en/wave_sel, slave returns dds_out/phase_wrap
interface dds_wave_gen_if;
  import dds_pkg::*;
  logic dds_en;
  logic [3:0] wave_sel;
  logic [DATA_W-1:0] dds_out;
  logic phase_wrap;
  modport master(output dds_en, wave_sel, input dds_out, phase_wrap);
  modport slave(input dds_en, wave_sel, output dds_out, phase_wrap);
endinterface

// File: rtl/dds_wave_gen_sine_rom.sv
// sine_rom: 4096x8 synchronous sine ROM; sys_clk, i_addr in, o_data one cycle later, contents fixed at elaboration
module sine_rom
  import dds_pkg::*;
(
  input  logic sys_clk,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] o_data
);
  logic [DATA_W-1:0] w_rom [1<<ADDR_W];
  for (genvar i = 0; i < (1 << ADDR_W); i++) begin : g_rom
    assign w_rom[i] = DATA_W'($rtoi(real'(MIDSCALE) + 127.5 * $sin(6.283185307179586 * i / 4096.0)));
  end
  always_ff @(posedge sys_clk) o_data <= w_rom[i_addr];
endmodule

// File: rtl/dds_wave_gen.sv
// dds_wave_gen: DDS core; sys_clk/sys_rst plain, bus.dds_en/wave_sel in, bus.dds_out/phase_wrap out after 3-stage pipeline
module dds_wave_gen
  import dds_pkg::*;
#(
  parameter logic [ACC_W-1:0] FREQ_CTRL = 32'd42950,
  parameter logic [ADDR_W-1:0] PHASE_CTRL = 12'd1024
) (
  input logic sys_clk,
  input logic sys_rst,
  dds_wave_gen_if.slave bus
);
  logic [ACC_W-1:0] r_acc;
  logic [ADDR_W-1:0] r_addr;
  logic [3:0] r_sel1, r_sel2, r_sel3;
  logic r_wrap1, r_wrap2, r_wrap3, r_wrap_out;
  logic [DATA_W-1:0] r_sq, r_tri, r_saw, r_out;
  logic [ACC_W:0] w_sum;
  logic [DATA_W-1:0] w_sine, w_mux;
  assign w_sum = {1'b0, r_acc} + {1'b0, FREQ_CTRL};
  sine_rom u_rom (.sys_clk(sys_clk), .i_addr(r_addr), .o_data(w_sine));
  always_comb w_mux = r_sel3 == WAVE_SINE ? w_sine :
                      r_sel3 == WAVE_SQUARE ? r_sq :
                      r_sel3 == WAVE_TRI ? r_tri :
                      r_sel3 == WAVE_SAW ? r_saw : '0;
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_acc <= '0;
      r_sel1 <= WAVE_MUTE;
      r_wrap1 <= 1'b0;
      r_addr <= '0;
      r_sel2 <= WAVE_MUTE;
      r_wrap2 <= 1'b0;
      r_sq <= '0;
      r_tri <= '0;
      r_saw <= '0;
      r_sel3 <= WAVE_MUTE;
      r_wrap3 <= 1'b0;
      r_out <= '0;
      r_wrap_out <= 1'b0;
    end else begin
      if (bus.dds_en) r_acc <= w_sum[ACC_W-1:0];
      r_wrap1 <= bus.dds_en & w_sum[ACC_W];
      if (bus.dds_en && w_sum[ACC_W] && sel_ok(bus.wave_sel)) r_sel1 <= bus.wave_sel;
      r_addr <= r_acc[ACC_W-1 -: ADDR_W] + PHASE_CTRL;
      r_sel2 <= r_sel1;
      r_wrap2 <= r_wrap1;
      r_sq <= {DATA_W{~r_addr[ADDR_W-1]}};
      r_tri <= r_addr[ADDR_W-1] ? ~r_addr[ADDR_W-2 -: DATA_W] : r_addr[ADDR_W-2 -: DATA_W];
      r_saw <= r_addr[ADDR_W-1 -: DATA_W];
      r_sel3 <= r_sel2;
      r_wrap3 <= r_wrap2;
      r_out <= w_mux;
      r_wrap_out <= r_wrap3;
    end
  end
  assign bus.dds_out = r_out;
  assign bus.phase_wrap = r_wrap_out;
endmodule

// File: tb/tb_dds_wave_gen.sv
// tb_dds_wave_gen: randomized self-checking bench for dds_wave_gen against a behavioural sample-stream model
module tb_dds_wave_gen;
  import dds_pkg::*;
  localparam int N = 3;
  localparam logic [31:0] F [N] = '{32'h0010_0000, 32'h0010_0000, 32'h0377_1a5b};
  localparam int P [N] = '{0, 1024, 3001};
  typedef struct packed {
    logic [31:0] acc;
    logic [3:0] sel;
    logic wrap;
  } smp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  logic [3:0] ws = 4'b0000;
  logic [7:0] obs_out [N];
  logic obs_wrap [N];
  smp_t pipe [N][3];
  logic [31:0] m_acc [N];
  logic [3:0] m_sel [N];
  logic [7:0] e_out [N];
  logic e_wrap [N];
  string nm [N] = '{"a", "b", "c"};
  int n_cmp = 0;
  int n_err = 0;
  int n;
  always #5 clk = ~clk;
  dds_wave_gen_if bus_a (), bus_b (), bus_c ();
  assign bus_a.dds_en = en;
  assign bus_b.dds_en = en;
  assign bus_c.dds_en = en;
  assign bus_a.wave_sel = ws;
  assign bus_b.wave_sel = ws;
  assign bus_c.wave_sel = ws;
  assign obs_out[0] = bus_a.dds_out;
  assign obs_out[1] = bus_b.dds_out;
  assign obs_out[2] = bus_c.dds_out;
  assign obs_wrap[0] = bus_a.phase_wrap;
  assign obs_wrap[1] = bus_b.phase_wrap;
  assign obs_wrap[2] = bus_c.phase_wrap;
  dds_wave_gen #(.FREQ_CTRL(F[0]), .PHASE_CTRL(12'(P[0]))) u_a (.sys_clk(clk), .sys_rst(rst), .bus(bus_a));
  dds_wave_gen #(.FREQ_CTRL(F[1]), .PHASE_CTRL(12'(P[1]))) u_b (.sys_clk(clk), .sys_rst(rst), .bus(bus_b));
  dds_wave_gen #(.FREQ_CTRL(F[2]), .PHASE_CTRL(12'(P[2]))) u_c (.sys_clk(clk), .sys_rst(rst), .bus(bus_c));
  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask
  function automatic int wave(input smp_t s, input int p);
    int a;
    a = (int'(s.acc[31:20]) + p) % 4096;
    case (s.sel)
      WAVE_SINE: return $rtoi($floor(127.5 + 127.5 * $sin(2.0 * 3.141592653589793 * a / 4096.0) + 0.5));
      WAVE_SQUARE: return a < 2048 ? 255 : 0;
      WAVE_TRI: return a < 2048 ? a / 8 : 255 - (a - 2048) / 8;
      WAVE_SAW: return a / 16;
      default: return 0;
    endcase
  endfunction
  task automatic model();
    for (int d = 0; d < N; d++) begin
      if (rst) begin
        m_acc[d] = '0;
        m_sel[d] = '0;
        for (int j = 0; j < 3; j++) pipe[d][j] = '0;
        e_out[d] = '0;
        e_wrap[d] = 1'b0;
      end else begin
        longint s;
        logic w;
        smp_t o;
        s = longint'(m_acc[d]) + longint'(F[d]);
        w = en && s >= 64'h1_0000_0000;
        o = pipe[d][0];
        if (en) m_acc[d] = s[31:0];
        if (w && $countones(ws) <= 1) m_sel[d] = ws;
        pipe[d][0] = pipe[d][1];
        pipe[d][1] = pipe[d][2];
        pipe[d][2] = {m_acc[d], m_sel[d], w};
        e_out[d] = 8'(wave(o, P[d]));
        e_wrap[d] = o.wrap;
      end
    end
  endtask
  task automatic step();
    @(posedge clk);
    model();
    #1;
    for (int d = 0; d < N; d++) begin
      chk({"out_", nm[d]}, int'(obs_out[d]), int'(e_out[d]));
      chk({"wrap_", nm[d]}, int'(obs_wrap[d]), int'(e_wrap[d]));
    end
  endtask
  task automatic steps(input int k);
    for (int i = 0; i < k; i++) step();
  endtask
  task automatic wait_wrap(input int lim, output int cnt);
    cnt = 0;
    do begin
      step();
      cnt++;
    end while (!obs_wrap[0] && cnt < lim);
    chk("wrap_seen", int'(obs_wrap[0]), 1);
  endtask
  initial begin
    steps(3);
    chk("rst_out", int'(obs_out[0]), 0);
    chk("rst_wrap", int'(obs_wrap[0]), 0);
    rst = 1'b0;
    en = 1'b1;
    ws = WAVE_SINE;
    steps(100);
    chk("pre_wrap_zero", int'(obs_out[0]), 0);
    ws = WAVE_SAW;
    wait_wrap(5000, n);
    chk("saw_wrap", int'(obs_out[0]), 0);
    steps(16);
    chk("saw_step16", int'(obs_out[0]), 1);
    steps(4079);
    chk("saw_top", int'(obs_out[0]), 255);
    wait_wrap(10, n);
    chk("period", 4095 + n, 4096);
    ws = WAVE_SINE;
    wait_wrap(5000, n);
    chk("sine_wrap_p0", int'(obs_out[0]), 128);
    chk("sine_wrap_p1024", int'(obs_out[1]), 255);
    steps(1024);
    chk("sine_q1", int'(obs_out[0]), 255);
    steps(2048);
    chk("sine_q3", int'(obs_out[0]), 0);
    ws = WAVE_SQUARE;
    wait_wrap(5000, n);
    steps(1000);
    ws = WAVE_TRI;
    steps(1000);
    chk("square_held", int'(obs_out[0]), 255);
    wait_wrap(5000, n);
    chk("tri_wrap", int'(obs_out[0]), 0);
    steps(2047);
    chk("tri_peak", int'(obs_out[0]), 255);
    ws = WAVE_SQUARE;
    wait_wrap(5000, n);
    steps(1000);
    ws = 4'b0110;
    wait_wrap(5000, n);
    chk("multihot_keep", int'(obs_out[0]), 255);
    steps(2048);
    chk("multihot_low", int'(obs_out[0]), 0);
    steps(500);
    en = 1'b0;
    steps(100);
    en = 1'b1;
    steps(200);
    rst = 1'b1;
    step();
    chk("mid_rst_acc", int'(u_a.r_acc), 0);
    chk("mid_rst_sel", int'(u_a.r_sel1), 0);
    chk("mid_rst_out", int'(obs_out[0]), 0);
    rst = 1'b0;
    for (int k = 0; k < 20000; k++) begin
      if ($urandom_range(0, 49) == 0) begin
        int r;
        r = int'($urandom_range(0, 6));
        ws = r < 4 ? 4'(1 << r) : r == 4 ? 4'b0000 : 4'($urandom_range(0, 15));
      end
      en = $urandom_range(0, 19) != 0;
      rst = $urandom_range(0, 999) == 0;
      step();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
